hydra_event_fifo: RTL

// Event buffer between the Hydra RX path and TX path. Stores WIDTH-bit packets presented by hydra_ctrl
// (rx_data/rx_data_flag) in a circular FIFO and replays them one at a time to hydra_ctrl (fifo_data/ld_tx_data).
// A TX scheduler FSM waits for the UARTs to go idle before each launch, so no packet is overwritten mid-transmit.

---
 rtl/hydra_event_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hydra_event_fifo.sv
// Circular event FIFO between the Hydra RX and TX paths with a TX launch scheduler.
// Optional odd-parity screening of incoming packets is enabled by defining PARITY_CHECK_EN.
module hydra_event_fifo #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic                  rx_data_flag,
    input  logic                  tx_busy_any,
    input  logic                  clear_flags,
    output logic [WIDTH-1:0]      fifo_data,
    output logic                  ld_tx_data,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  parity_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD      = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [2:0]            tmo, tmo_nxt;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [CW-1:0]         count_nxt;
    logic                  launch_c, pop_c, parity_ok_c, wr_c, ovf_set_c;

    // TX scheduler: next state, timeout counter, launch and pop strobes
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo;
        launch_c  = 1'b0;
        pop_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && !tx_busy_any) begin
                    state_nxt = S_LOAD;
                    launch_c  = 1'b1;
                end
            end
            S_LOAD: begin
                state_nxt = S_WAIT_BUSY;
                tmo_nxt   = 3'd0;
            end
            S_WAIT_BUSY: begin
                tmo_nxt = tmo + 3'd1;
                // Timeout covers the case where no UART is enabled and busy never rises
                if (tx_busy_any || (tmo == 3'd6)) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy_any) begin
                    state_nxt = S_IDLE;
                    pop_c     = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef PARITY_CHECK_EN
    assign parity_ok_c = ^rx_data;
`else
    assign parity_ok_c = 1'b1;
`endif

    // A full FIFO still accepts a write when a pop frees a slot on the same edge
    assign wr_c      = rx_data_flag && parity_ok_c && (!fifo_full || pop_c);
    assign ovf_set_c = rx_data_flag && parity_ok_c && fifo_full && !pop_c;

    always_comb begin
        count_nxt = fifo_count;
        if (wr_c && !pop_c) begin
            count_nxt = fifo_count + CW'(1);
        end else if (!wr_c && pop_c) begin
            count_nxt = fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            tmo        <= 3'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            fifo_data  <= '0;
            ld_tx_data <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            tmo        <= tmo_nxt;
            ld_tx_data <= launch_c;
            fifo_count <= count_nxt;
            fifo_empty <= (count_nxt == CW'(0));
            fifo_full  <= (count_nxt == CW'(DEPTH));
            if (wr_c) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (launch_c) begin
                fifo_data <= mem[rd_ptr];
            end
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
        end
    end

    // Packet storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= rx_data;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else if (rx_data_flag && !parity_ok_c) begin
            parity_err <= 1'b1;
        end else if (clear_flags) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
